servo_pwm_gen: RTL and testbench
================================

Name: servo_pwm_gen

Overview:
- Servo PWM generator. Consumes a pulse-width command in clock cycles from the marble-dispense and other servo-command blocks, and drives the physical servo control pin.
- Produces a fixed-period pulse train whose high time follows the command. Width changes take effect only at period boundaries, with clamping and optional slew limiting.
- Reports period starts and a "settled" status back toward the main state machine.

Parameters:
- PERIOD, 2_000_000: PWM period in clk cycles (20 ms at 100 MHz).
- MIN_WIDTH, 50_000: minimum legal nonzero high time, in cycles.
- MAX_WIDTH, 250_000: maximum legal high time, in cycles.
- STEP, 0: maximum change of the active width per period, in cycles; 0 means no slew limit.
- SETTLE_PERIODS, 10: number of complete periods at the target width before settled asserts.
- WIDTH_W, 20: width of the command and active-width buses.
- CNT_W, 21: width of the period counter; must satisfy 2^CNT_W > PERIOD.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- enable, input, 1: run request from the main state machine.
- width_in, input, WIDTH_W: commanded high time in cycles; 0 means no pulse (servo relaxed).
- pwm_out, output, 1: servo control pin, registered.
- width_active, output, WIDTH_W: high time in use for the current period.
- period_start, output, 1: one-cycle pulse in the first cycle of each period (count==0).
- settled, output, 1: active width equals target and has held for SETTLE_PERIODS periods.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, count=0, width_active=0, target=0, settle_cnt=0, pwm_out=0, period_start=0, settled=0. rst overrides every other input, including mid-pulse; pwm_out is low the cycle after rst is sampled.
- width_in passes through one register (w_sync); all decisions use w_sync.
- Clamp function: clamp(0)=0; clamp(w)=MIN_WIDTH if 0<w<MIN_WIDTH; clamp(w)=MAX_WIDTH if w>MAX_WIDTH; otherwise clamp(w)=w.
- State IDLE: count=0, pwm_out=0, settled=0, settle_cnt=0.
  - On an edge with enable=1: go to RUN.
  - This is a boundary edge with first=1.
- State RUN: count increments every cycle. The edge at count==PERIOD-1 is a boundary edge (first=0), and count wraps to 0.
  - enable=0 sampled in RUN → go to DRAIN. count continues; no truncation of the pulse in progress.
- State DRAIN: same counting as RUN.
  - enable=1 → go back to RUN with no gap.
  - At count==PERIOD-1 with enable=0 → go to IDLE, count=0. No boundary update happens on this edge.
  - At count==PERIOD-1 with enable=1 → normal boundary edge, stay in RUN.
- Boundary edge actions:
  - target <= clamp(w_sync).
  - width_active <= next value:
    - first=1, or STEP=0, or new target==0, or width_active==0: next = target (jump directly).
    - otherwise: next moves from width_active toward target by at most STEP, never overshooting.
  - period_start is high in the following cycle, which is count==0.
- pwm_out is high exactly in the cycles where state∈{RUN,DRAIN} and count<width_active. It is registered and aligned to count, with no combinational path to the pin.
  - width_active==0 → pwm_out stays low for the whole period.
  - width_active never exceeds MAX_WIDTH, so pwm_out is guaranteed low for the tail of every period when MAX_WIDTH<PERIOD.
- Settling:
  - At each boundary edge, if the new width_active equals the new target and the width did not change, settle_cnt increments, saturating at SETTLE_PERIODS. Otherwise settle_cnt=0.
  - settled = (settle_cnt==SETTLE_PERIODS), registered.
  - Leaving to IDLE clears settle_cnt and settled.
- width_in may change at any cycle. Only the value sampled at a boundary is used; mid-period changes never alter the current pulse.
- Simultaneous events:
  - rst beats enable.
  - In DRAIN, enable re-assertion at count==PERIOD-1 keeps the block running.
  - A target change at a boundary resets settle_cnt even if the slew step reaches it in the same period.

Decomposition:
- Shared package holds:
  - State encoding (IDLE, RUN, DRAIN).
  - Default servo timing constants (SERVO_PERIOD, SERVO_MIN_WIDTH, SERVO_MAX_WIDTH). The marble dispenser widths (240000, 65000) also move there, so command producers and this block share one source.
- One natural sub-module: servo_width_shaper. It is purely boundary-driven and contains the clamp, slew step and settle counter. The top level keeps the period counter, the FSM and pwm_out.

Test Plan:
(All cases use PERIOD=100, MIN_WIDTH=5, MAX_WIDTH=25, STEP=4, SETTLE_PERIODS=3 unless noted.)
- Basic pulse: width_in=10, enable=1 from IDLE → period_start every 100 cycles; pwm_out high for exactly 10 cycles starting at count 0; settled=1 after the 3rd full period.
- Clamp: width_in=2 → width_active=5; width_in=40 → width_active=25; width_in=0 → pwm_out low all period, width_active=0.
- Slew: running settled at 10, width_in→23 → per-period widths 14, 18, 22, 23; settled=0 during the ramp, 1 three periods after reaching 23. With STEP=0 the width jumps to 23 in one period.
- Mid-period change: width_in changes 10→20 at count 50 → current pulse unchanged; new width appears only at the next boundary.
- Drain: enable deasserted at count 3 with width 10 → full 10-cycle pulse completes, IDLE entered at period end, pwm_out=0, settled=0. Re-asserting enable at count 99 of DRAIN → next period starts with no gap.
- Reset mid-pulse: rst at count 4 with width 20 → next cycle pwm_out=0, width_active=0, count=0, state IDLE; restart with enable requires a full new period.

Source files
------------

// File: rtl/servo_pwm_gen_pkg.sv
// Shared definitions for the servo PWM path: FSM encoding and default servo
// timing, including the marble dispenser command widths used by producers.
package servo_pwm_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pwm_state_t;

    // 20 ms frame, 0.5 ms .. 2.5 ms pulse at a 100 MHz clock
    localparam int SERVO_PERIOD    = 2_000_000;
    localparam int SERVO_MIN_WIDTH = 50_000;
    localparam int SERVO_MAX_WIDTH = 250_000;

    // Marble dispenser gate positions, in clk cycles of high time
    localparam int MARBLE_RELEASE_WIDTH = 240_000;
    localparam int MARBLE_HOLD_WIDTH    = 65_000;

endpackage

// File: rtl/servo_width_shaper.sv
// Boundary-driven width shaping: clamps the sampled command, slews the active
// width toward it and tracks how long the output has been stable at target.
module servo_width_shaper
    import servo_pwm_gen_pkg::*;
#(
    parameter int MIN_WIDTH      = SERVO_MIN_WIDTH,
    parameter int MAX_WIDTH      = SERVO_MAX_WIDTH,
    parameter int STEP           = 0,
    parameter int SETTLE_PERIODS = 10,
    parameter int WIDTH_W        = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               boundary,
    input  logic               first,
    input  logic               clear,
    input  logic [WIDTH_W-1:0] w_sync,
    output logic [WIDTH_W-1:0] width_next,
    output logic [WIDTH_W-1:0] width_active,
    output logic               settled
);

    localparam int SC_W = (SETTLE_PERIODS > 0) ? $clog2(SETTLE_PERIODS + 1) : 1;

    localparam logic [WIDTH_W-1:0]        MIN_W      = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0]        MAX_W      = WIDTH_W'(MAX_WIDTH);
    localparam logic [WIDTH_W-1:0]        STEP_W     = WIDTH_W'(STEP);
    localparam logic signed [WIDTH_W:0]   STEP_S     = (WIDTH_W+1)'(STEP);
    localparam logic [SC_W-1:0]           SETTLE_MAX = SC_W'(SETTLE_PERIODS);

    logic [WIDTH_W-1:0] target;
    logic [WIDTH_W-1:0] target_next;
    logic [SC_W-1:0]    settle_cnt;
    logic [SC_W-1:0]    settle_next;

    // Zero is a legal "relaxed" command and passes through untouched
    function automatic logic [WIDTH_W-1:0] clamp(input logic [WIDTH_W-1:0] w);
        if (w == '0) begin
            return '0;
        end else if (w < MIN_W) begin
            return MIN_W;
        end else if (w > MAX_W) begin
            return MAX_W;
        end else begin
            return w;
        end
    endfunction

    function automatic logic [WIDTH_W-1:0] slew(input logic [WIDTH_W-1:0] cur,
                                                input logic [WIDTH_W-1:0] tgt,
                                                input logic               is_first);
        logic signed [WIDTH_W:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (is_first || (STEP == 0) || (tgt == '0) || (cur == '0)) begin
            return tgt;
        end else if (diff > STEP_S) begin
            return cur + STEP_W;
        end else if (diff < -STEP_S) begin
            return cur - STEP_W;
        end else begin
            return tgt;
        end
    endfunction

    // Any movement of width or target restarts the settle count
    always_comb begin
        target_next = clamp(w_sync);
        width_next  = slew(width_active, target_next, first);
        settle_next = '0;
        if ((width_next == target_next) && (width_next == width_active) &&
            (target_next == target)) begin
            settle_next = (settle_cnt == SETTLE_MAX) ? settle_cnt : settle_cnt + SC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            width_active <= '0;
            target       <= '0;
            settle_cnt   <= '0;
            settled      <= 1'b0;
        end else if (clear) begin
            settle_cnt <= '0;
            settled    <= 1'b0;
        end else if (boundary) begin
            width_active <= width_next;
            target       <= target_next;
            settle_cnt   <= settle_next;
            settled      <= (settle_next == SETTLE_MAX);
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: fixed-period frame counter, run/drain/idle control and
// a registered pin whose high time is updated only at period boundaries.
module servo_pwm_gen
    import servo_pwm_gen_pkg::*;
#(
    parameter int PERIOD         = SERVO_PERIOD,
    parameter int MIN_WIDTH      = SERVO_MIN_WIDTH,
    parameter int MAX_WIDTH      = SERVO_MAX_WIDTH,
    parameter int STEP           = 0,
    parameter int SETTLE_PERIODS = 10,
    parameter int WIDTH_W        = 20,
    parameter int CNT_W          = 21
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [WIDTH_W-1:0] width_in,
    output logic               pwm_out,
    output logic [WIDTH_W-1:0] width_active,
    output logic               period_start,
    output logic               settled
);

    localparam int               CMP_W = (CNT_W > WIDTH_W) ? CNT_W : WIDTH_W;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

    pwm_state_t         state;
    pwm_state_t         state_next;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [WIDTH_W-1:0] w_sync;
    logic [WIDTH_W-1:0] width_next;
    logic [WIDTH_W-1:0] width_eff;
    logic               at_last;
    logic               boundary;
    logic               first;
    logic               clear_settle;
    logic               pwm_next;

    // Command is registered once; every decision looks at w_sync only
    always_ff @(posedge clk) begin
        w_sync <= width_in;
    end

    assign at_last = (count == LAST);

    always_comb begin
        state_next   = state;
        count_next   = count;
        boundary     = 1'b0;
        first        = 1'b0;
        clear_settle = 1'b0;
        case (state)
            ST_IDLE: begin
                count_next = '0;
                if (enable) begin
                    state_next = ST_RUN;
                    boundary   = 1'b1;
                    first      = 1'b1;
                end
            end
            ST_RUN: begin
                count_next = at_last ? '0 : count + CNT_W'(1);
                boundary   = at_last;
                if (!enable) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                count_next = at_last ? '0 : count + CNT_W'(1);
                if (enable) begin
                    state_next = ST_RUN;
                    boundary   = at_last;
                end else if (at_last) begin
                    // Frame finished with no run request: stop without a new update
                    state_next   = ST_IDLE;
                    clear_settle = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    // Pin is computed from next-cycle count/width so it lines up with count
    always_comb begin
        width_eff = boundary ? width_next : width_active;
        pwm_next  = (state_next != ST_IDLE) && (CMP_W'(count_next) < CMP_W'(width_eff));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            count        <= '0;
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            pwm_out      <= pwm_next;
            period_start <= boundary;
        end
    end

    servo_width_shaper #(
        .MIN_WIDTH      (MIN_WIDTH),
        .MAX_WIDTH      (MAX_WIDTH),
        .STEP           (STEP),
        .SETTLE_PERIODS (SETTLE_PERIODS),
        .WIDTH_W        (WIDTH_W)
    ) u_shaper (
        .clk          (clk),
        .rst          (rst),
        .boundary     (boundary),
        .first        (first),
        .clear        (clear_settle),
        .w_sync       (w_sync),
        .width_next   (width_next),
        .width_active (width_active),
        .settled      (settled)
    );

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Directed bench for servo_pwm_gen using a short 100-cycle frame; a second
// instance without slew limiting shares the same stimulus.
module tb_servo_pwm_gen;

    localparam int PER = 100;
    localparam int WW  = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [WW-1:0] width_in = '0;
    logic          pwm_out, period_start, settled;
    logic [WW-1:0] width_active;
    logic          pwm_ns, period_start_ns, settled_ns;
    logic [WW-1:0] width_active_ns;

    int            tests = 0;
    int            fails = 0;
    int            hi, bad, hi2, cnt;
    logic [WW-1:0] wa, wa2;
    logic          ps, ok;

    always #5 clk = ~clk;

    servo_pwm_gen #(.PERIOD(PER), .MIN_WIDTH(5), .MAX_WIDTH(25), .STEP(4),
                    .SETTLE_PERIODS(3), .WIDTH_W(WW), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .enable(enable), .width_in(width_in),
        .pwm_out(pwm_out), .width_active(width_active),
        .period_start(period_start), .settled(settled));

    servo_pwm_gen #(.PERIOD(PER), .MIN_WIDTH(5), .MAX_WIDTH(25), .STEP(0),
                    .SETTLE_PERIODS(3), .WIDTH_W(WW), .CNT_W(7)) dut_ns (
        .clk(clk), .rst(rst), .enable(enable), .width_in(width_in),
        .pwm_out(pwm_ns), .width_active(width_active_ns),
        .period_start(period_start_ns), .settled(settled_ns));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ps(output logic found);
        found = 1'b0;
        for (int n = 0; n < 3 * PER; n++) begin
            tick();
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Walks one frame starting at its count==0 sample, applying optional
    // mid-frame input changes; leaves the bench at the next frame's first cycle.
    task automatic measure(input int exp_w, input int chg_at, input logic [WW-1:0] chg_val,
                           input int off_at, input int on_at,
                           output int o_hi, output int o_bad, output logic [WW-1:0] o_wa,
                           output int o_hi2, output logic [WW-1:0] o_wa2, output logic o_ps);
        o_hi = 0; o_bad = 0; o_hi2 = 0;
        o_wa = width_active; o_wa2 = width_active_ns;
        for (int i = 0; i < PER; i++) begin
            if (pwm_out === 1'b1) o_hi++;
            if (pwm_ns === 1'b1) o_hi2++;
            if (pwm_out !== logic'(i < exp_w)) o_bad++;
            if (period_start !== logic'(i == 0)) o_bad++;
            if (i == chg_at) width_in = chg_val;
            if (i == off_at) enable = 1'b0;
            if (i == on_at) enable = 1'b1;
            tick();
        end
        o_ps = period_start;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; width_in = '0;
        repeat (3) tick();
        tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
        tests++; if (width_active !== '0) begin fails++; $display("FAIL reset_width: got %0d want 0", width_active); end
        tests++; if (period_start !== 1'b0) begin fails++; $display("FAIL reset_ps: got %b want 0", period_start); end
        tests++; if (settled !== 1'b0) begin fails++; $display("FAIL reset_settled: got %b want 0", settled); end
        tests++; if (width_active_ns !== '0) begin fails++; $display("FAIL reset_width_ns: got %0d want 0", width_active_ns); end
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pwm_out !== 1'b0 || period_start !== 1'b0) cnt++;
        end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL idle_quiet: got %0d active cycles want 0", cnt); end
    endtask

    task automatic test_basic();
        width_in = 20'd10;
        tick(); tick();
        enable = 1'b1;
        wait_ps(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL basic_start: no period_start within %0d cycles", 3 * PER); end
        tests++; if (settled !== 1'b0) begin fails++; $display("FAIL basic_settled_p1: got %b want 0", settled); end
        measure(10, -1, '0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (hi !== 10) begin fails++; $display("FAIL basic_hi: got %0d want 10", hi); end
        tests++; if (bad !== 0) begin fails++; $display("FAIL basic_shape: got %0d bad cycles want 0", bad); end
        tests++; if (wa !== 20'd10) begin fails++; $display("FAIL basic_width: got %0d want 10", wa); end
        tests++; if (ps !== 1'b1) begin fails++; $display("FAIL basic_period: got %b want 1 at cycle 100", ps); end
        for (int p = 2; p <= 3; p++) begin
            tests++; if (settled !== 1'b0) begin fails++; $display("FAIL basic_settled_p%0d: got %b want 0", p, settled); end
            measure(10, -1, '0, -1, -1, hi, bad, wa, hi2, wa2, ps);
            tests++; if (bad !== 0) begin fails++; $display("FAIL basic_shape_p%0d: got %0d bad want 0", p, bad); end
        end
        tests++; if (settled !== 1'b1) begin fails++; $display("FAIL basic_settled_p4: got %b want 1", settled); end
    endtask

    task automatic test_clamp();
        measure(10, 10, 20'd0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        measure(0, 10, 20'd2, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (wa !== 20'd0) begin fails++; $display("FAIL clamp_zero_width: got %0d want 0", wa); end
        tests++; if (hi !== 0 || bad !== 0) begin fails++; $display("FAIL clamp_zero_pwm: got hi=%0d bad=%0d want 0/0", hi, bad); end
        measure(5, 10, 20'd0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (wa !== 20'd5) begin fails++; $display("FAIL clamp_low_width: got %0d want 5", wa); end
        tests++; if (hi !== 5 || bad !== 0) begin fails++; $display("FAIL clamp_low_pwm: got hi=%0d bad=%0d want 5/0", hi, bad); end
        measure(0, 10, 20'd40, -1, -1, hi, bad, wa, hi2, wa2, ps);
        measure(25, 10, 20'd0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (wa !== 20'd25) begin fails++; $display("FAIL clamp_high_width: got %0d want 25", wa); end
        tests++; if (hi !== 25 || bad !== 0) begin fails++; $display("FAIL clamp_high_pwm: got hi=%0d bad=%0d want 25/0", hi, bad); end
        tests++; if (wa2 !== 20'd25) begin fails++; $display("FAIL clamp_high_ns: got %0d want 25", wa2); end
    endtask

    task automatic test_slew();
        int ramp [4] = '{14, 18, 22, 23};
        measure(0, 10, 20'd10, -1, -1, hi, bad, wa, hi2, wa2, ps);
        for (int p = 0; p < 3; p++) measure(10, -1, '0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (settled !== 1'b1) begin fails++; $display("FAIL slew_presettled: got %b want 1", settled); end
        tests++; if (settled_ns !== 1'b1) begin fails++; $display("FAIL slew_presettled_ns: got %b want 1", settled_ns); end
        measure(10, 10, 20'd23, -1, -1, hi, bad, wa, hi2, wa2, ps);
        for (int k = 0; k < 4; k++) begin
            tests++; if (settled !== 1'b0) begin fails++; $display("FAIL slew_settled_%0d: got %b want 0", k, settled); end
            measure(ramp[k], -1, '0, -1, -1, hi, bad, wa, hi2, wa2, ps);
            tests++; if (wa !== WW'(ramp[k]) || hi !== ramp[k] || bad !== 0) begin
                fails++; $display("FAIL slew_step_%0d: got width=%0d hi=%0d bad=%0d want %0d/%0d/0", k, wa, hi, bad, ramp[k], ramp[k]);
            end
            if (k == 0) begin
                tests++; if (wa2 !== 20'd23 || hi2 !== 23) begin fails++; $display("FAIL slew_nolimit: got width=%0d hi=%0d want 23/23", wa2, hi2); end
            end
        end
        tests++; if (settled_ns !== 1'b1) begin fails++; $display("FAIL slew_settled_ns: got %b want 1", settled_ns); end
        tests++; if (settled !== 1'b0) begin fails++; $display("FAIL slew_settled_hold1: got %b want 0", settled); end
        measure(23, -1, '0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (settled !== 1'b0) begin fails++; $display("FAIL slew_settled_hold2: got %b want 0", settled); end
        measure(23, -1, '0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (settled !== 1'b1) begin fails++; $display("FAIL slew_settled_final: got %b want 1", settled); end
    endtask

    task automatic test_midperiod();
        measure(23, 10, 20'd0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        measure(0, 10, 20'd10, -1, -1, hi, bad, wa, hi2, wa2, ps);
        measure(10, 50, 20'd20, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (hi !== 10 || bad !== 0) begin fails++; $display("FAIL mid_current: got hi=%0d bad=%0d want 10/0", hi, bad); end
        tests++; if (hi2 !== 10) begin fails++; $display("FAIL mid_current_ns: got hi=%0d want 10", hi2); end
        measure(14, 5, 20'd0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (wa !== 20'd14 || bad !== 0) begin fails++; $display("FAIL mid_next: got width=%0d bad=%0d want 14/0", wa, bad); end
        tests++; if (wa2 !== 20'd20 || hi2 !== 20) begin fails++; $display("FAIL mid_next_ns: got width=%0d hi=%0d want 20/20", wa2, hi2); end
    endtask

    task automatic test_drain();
        measure(0, 5, 20'd10, -1, -1, hi, bad, wa, hi2, wa2, ps);
        measure(10, -1, '0, 3, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (hi !== 10 || bad !== 0) begin fails++; $display("FAIL drain_pulse: got hi=%0d bad=%0d want 10/0", hi, bad); end
        tests++; if (ps !== 1'b0) begin fails++; $display("FAIL drain_no_restart: got period_start=%b want 0", ps); end
        tests++; if (pwm_out !== 1'b0 || settled !== 1'b0) begin fails++; $display("FAIL drain_idle: got pwm=%b settled=%b want 0/0", pwm_out, settled); end
        cnt = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (pwm_out !== 1'b0 || period_start !== 1'b0) cnt++;
        end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL drain_idle_quiet: got %0d active cycles want 0", cnt); end
        enable = 1'b1;
        wait_ps(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL drain_restart: no period_start within %0d cycles", 3 * PER); end
        measure(10, -1, '0, 3, 99, hi, bad, wa, hi2, wa2, ps);
        tests++; if (bad !== 0 || ps !== 1'b1) begin fails++; $display("FAIL drain_reassert: got bad=%0d period_start=%b want 0/1", bad, ps); end
        measure(10, -1, '0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (wa !== 20'd10 || hi !== 10 || bad !== 0) begin fails++; $display("FAIL drain_continue: got width=%0d hi=%0d bad=%0d want 10/10/0", wa, hi, bad); end
    endtask

    task automatic test_reset_midpulse();
        measure(10, 5, 20'd0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        measure(0, 5, 20'd20, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (width_active !== 20'd20) begin fails++; $display("FAIL rstmid_pre_width: got %0d want 20", width_active); end
        repeat (4) tick();
        tests++; if (pwm_out !== 1'b1) begin fails++; $display("FAIL rstmid_pre_pwm: got %b want 1", pwm_out); end
        rst = 1'b1; enable = 1'b0;
        tick();
        tests++; if (pwm_out !== 1'b0 || width_active !== '0 || period_start !== 1'b0 || settled !== 1'b0) begin
            fails++; $display("FAIL rstmid_after: got pwm=%b width=%0d ps=%b settled=%b want 0/0/0/0", pwm_out, width_active, period_start, settled);
        end
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pwm_out !== 1'b0) cnt++;
        end
        tests++; if (cnt !== 0) begin fails++; $display("FAIL rstmid_idle: got %0d high cycles want 0", cnt); end
        enable = 1'b1;
        wait_ps(ok);
        tests++; if (ok !== 1'b1) begin fails++; $display("FAIL rstmid_restart: no period_start within %0d cycles", 3 * PER); end
        measure(20, -1, '0, -1, -1, hi, bad, wa, hi2, wa2, ps);
        tests++; if (wa !== 20'd20 || hi !== 20 || bad !== 0) begin fails++; $display("FAIL rstmid_full: got width=%0d hi=%0d bad=%0d want 20/20/0", wa, hi, bad); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clamp();
        test_slew();
        test_midperiod();
        test_drain();
        test_reset_midpulse();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
